// File: rtl/iterative_exec_unit_pkg.sv
// iterative_exec_unit_pkg: shared execution-stage opcode constants and FSM states
package iterative_exec_unit_pkg;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    // Only SUB and SRA exist under the alternate funct7.
    function automatic logic base_legal(input logic [2:0] f3, input logic [6:0] f7);
        return f7 == FUNCT7_BASE || (f7 == FUNCT7_ALT && (f3 == F3_ADD || f3 == F3_SR));
    endfunction

endpackage

// File: rtl/iterative_exec_unit_muldiv_iter.sv
// iterative_exec_unit_muldiv_iter: shared shift-add multiply / restoring divide iteration datapath
module iterative_exec_unit_muldiv_iter
    import iterative_exec_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             hi_i,
    input  logic             neg_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    logic               active_q, div_q, hi_q, neg_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH:0]     add_sum, rem_sh, diff;
    logic [WIDTH-1:0]   half;

    // acc holds {high, low}: product/multiplier for MUL, remainder/quotient for DIV
    assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff    = rem_sh - {1'b0, b_q};
    assign acc_d   = !div_q ? {add_sum, acc_q[WIDTH-1:1]}
                   : diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // The final step's value is used directly, so the sign fix-up happens on that step.
    // A signed product is negated as a whole; quotient and remainder are negated alone.
    assign prod     = (neg_q && !div_q) ? -acc_d : acc_d;
    assign half     = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    assign result_o = (neg_q && div_q) ? -half : half;
    assign done_o   = active_q && cnt_q == SHAMT_W'(WIDTH - 1);

    // Load operands on start, then advance one bit per cycle for WIDTH cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            div_q    <= 1'b0;
            hi_q     <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            b_q      <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            div_q    <= div_i;
            hi_q     <= hi_i;
            neg_q    <= neg_i;
            cnt_q    <= '0;
            b_q      <= b_i;
            acc_q    <= {{WIDTH{1'b0}}, a_i};
        end else if (active_q) begin
            active_q <= !done_o;
            cnt_q    <= cnt_q + SHAMT_W'(1);
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/iterative_exec_unit.sv
// iterative_exec_unit: handshaked RV32I ALU plus iterative RV32M multiply/divide
module iterative_exec_unit
    import iterative_exec_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [2:0]       func,
    input  logic [6:0]       auxFunc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             illegal,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_e             state_q, req_state;
    logic [WIDTH-1:0]   out_q, req_out, alu_res, sra_res, a_mag, b_mag, md_result;
    logic               illegal_q, out_valid_q, busy_q, req_ill, accept, alt;
    logic               a_sgn, b_sgn, a_neg, b_neg, md_div, md_hi, md_neg;
    logic               div_zero, div_ovf, md_start, md_done;
    logic [SHAMT_W-1:0] shamt;

    assign in_ready  = state_q == S_IDLE || (state_q == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign alt       = auxFunc == FUNCT7_ALT;
    assign shamt     = opB[SHAMT_W-1:0];
    assign sra_res   = $signed(opA) >>> shamt;

    // Base ALU result, evaluated on the operands present at acceptance
    always_comb begin
        alu_res = '0;
        case (func)
            F3_ADD:  alu_res = alt ? opA - opB : opA + opB;
            F3_SLL:  alu_res = opA << shamt;
            F3_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
            F3_SLTU: alu_res = {{(WIDTH-1){1'b0}}, opA < opB};
            F3_XOR:  alu_res = opA ^ opB;
            F3_SR:   alu_res = alt ? sra_res : opA >> shamt;
            F3_OR:   alu_res = opA | opB;
            F3_AND:  alu_res = opA & opB;
            default: alu_res = '0;
        endcase
    end

    // M-op decode: operand signedness, divide vs multiply, and which half is returned
    always_comb begin
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        md_div = 1'b0;
        md_hi  = 1'b1;
        case (func)
            F3_MUL:    md_hi = 1'b0;
            F3_MULH:   {a_sgn, b_sgn} = 2'b11;
            F3_MULHSU: a_sgn = 1'b1;
            F3_MULHU:  md_hi = 1'b1;
            F3_DIV:    {a_sgn, b_sgn, md_div, md_hi} = 4'b1110;
            F3_DIVU:   {md_div, md_hi} = 2'b10;
            F3_REM:    {a_sgn, b_sgn, md_div} = 3'b111;
            F3_REMU:   md_div = 1'b1;
            default:   md_hi = 1'b1;
        endcase
    end

    assign a_neg    = a_sgn && opA[WIDTH-1];
    assign b_neg    = b_sgn && opB[WIDTH-1];
    assign a_mag    = a_neg ? -opA : opA;
    assign b_mag    = b_neg ? -opB : opB;
    assign md_neg   = (md_div && md_hi) ? a_neg : a_neg ^ b_neg;
    assign div_zero = md_div && opB == '0;
    assign div_ovf  = md_div && a_sgn && opA == MIN_NEG && opB == ALL_ONES;

    // Where an accepted request goes and, for single-cycle cases, what it returns
    always_comb begin
        req_state = S_DONE;
        req_out   = '0;
        req_ill   = 1'b0;
        if (base_legal(func, auxFunc))
            req_out = alu_res;
        else if (auxFunc == FUNCT7_MULDIV) begin
            if (!md_div)
                req_state = S_MUL;
            else if (div_zero)
                req_out = md_hi ? opA : ALL_ONES;
            else if (div_ovf)
                req_out = md_hi ? '0 : opA;
            else
                req_state = S_DIV;
        end else
            req_ill = 1'b1;
    end

    assign md_start = accept && (req_state == S_MUL || req_state == S_DIV);

    iterative_exec_unit_muldiv_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_muldiv_iter (
        .clk_i    (clk),
        .rst_ni   (rst),
        .start_i  (md_start),
        .div_i    (md_div),
        .hi_i     (md_hi),
        .neg_i    (md_neg),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Control FSM with registered result and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            state_q     <= req_state;
            out_q       <= req_out;
            illegal_q   <= req_ill;
            out_valid_q <= req_state == S_DONE;
            busy_q      <= req_state != S_DONE;
        end else if (state_q == S_DONE && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else if (busy_q && md_done) begin
            state_q     <= S_DONE;
            out_q       <= md_result;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iterative_exec_unit.sv
// tb_iterative_exec_unit: table-driven scoreboard bench for iterative_exec_unit
module tb_iterative_exec_unit;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          acc;
    } sb_t;

    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, illegal, busy;
    logic [31:0] opA = '0, opB = '0, out;
    logic [2:0]  func = '0;
    logic [6:0]  auxFunc = '0;
    int          cyc = 0, n_vec = 0, n_err = 0, seen_cyc = 0;
    bit          seen = 1'b0;
    vec_t        vt[$];
    sb_t         sb[$];

    iterative_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .func      (func),
        .auxFunc   (auxFunc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] r, input logic il, input int lat);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.f3 = f3; v.f7 = f7; v.res = r; v.ill = il; v.lat = lat;
        vt.push_back(v);
    endfunction

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send(input vec_t v);
        int  guard = 0;
        sb_t e;
        opA = v.a; opB = v.b; func = v.f3; auxFunc = v.f7; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s accept: in_ready stayed 0, expected 1", v.name);
        end else begin
            e.name = v.name; e.res = v.res; e.ill = v.ill; e.lat = v.lat; e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard monitor: latency is taken from the first cycle a result is valid
    always begin
        sb_t e;
        @(negedge clk);
        #3;
        if (!rst)
            seen = 1'b0;
        else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                seen_cyc = cyc;
            end
            if (out_ready) begin
                seen = 1'b0;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h, expected no result", out);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " out"}, out, e.res);
                    check({e.name, " illegal"}, 32'(illegal), 32'(e.ill));
                    check({e.name, " latency"}, seen_cyc - e.acc, e.lat);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        vec_t v;
        int nb, guard;
        add("ADD",     32'd5,        32'd7,        3'd0, 7'h00, 32'd12,       1'b0, 1);
        add("SUB",     32'd5,        32'd7,        3'd0, 7'h20, 32'hFFFFFFFE, 1'b0, 1);
        add("SRA",     32'h80000000, 32'd4,        3'd5, 7'h20, 32'hF8000000, 1'b0, 1);
        add("SRL",     32'h80000000, 32'd4,        3'd5, 7'h00, 32'h08000000, 1'b0, 1);
        add("SLT",     32'hFFFFFFFF, 32'd1,        3'd2, 7'h00, 32'd1,        1'b0, 1);
        add("SLTU",    32'hFFFFFFFF, 32'd1,        3'd3, 7'h00, 32'd0,        1'b0, 1);
        add("SLL31",   32'd1,        32'd31,       3'd1, 7'h00, 32'h80000000, 1'b0, 1);
        add("SLLhi",   32'd3,        32'd33,       3'd1, 7'h00, 32'd6,        1'b0, 1);
        add("XOR",     32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 7'h00, 32'hFF00FF00, 1'b0, 1);
        add("OR",      32'h0000000F, 32'h000000F0, 3'd6, 7'h00, 32'h000000FF, 1'b0, 1);
        add("AND",     32'h0000F0F0, 32'h0000FF00, 3'd7, 7'h00, 32'h0000F000, 1'b0, 1);
        add("MULH",    32'h80000000, 32'h80000000, 3'd1, 7'h01, 32'h40000000, 1'b0, 33);
        add("MUL",     32'h80000000, 32'h80000000, 3'd0, 7'h01, 32'd0,        1'b0, 33);
        add("MULHU",   32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 7'h01, 32'hFFFFFFFE, 1'b0, 33);
        add("MULHSU",  32'hFFFFFFFF, 32'd2,        3'd2, 7'h01, 32'hFFFFFFFF, 1'b0, 33);
        add("MULneg",  32'hFFFFFFFD, 32'd7,        3'd0, 7'h01, 32'hFFFFFFEB, 1'b0, 33);
        add("MULHneg", 32'hFFFFFFFD, 32'd7,        3'd1, 7'h01, 32'hFFFFFFFF, 1'b0, 33);
        add("MULHm1",  32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 7'h01, 32'd0,        1'b0, 33);
        add("DIV",     32'hFFFFFFF9, 32'd2,        3'd4, 7'h01, 32'hFFFFFFFD, 1'b0, 33);
        add("REM",     32'hFFFFFFF9, 32'd2,        3'd6, 7'h01, 32'hFFFFFFFF, 1'b0, 33);
        add("DIVnb",   32'd7,        32'hFFFFFFFE, 3'd4, 7'h01, 32'hFFFFFFFD, 1'b0, 33);
        add("REMnb",   32'd7,        32'hFFFFFFFE, 3'd6, 7'h01, 32'd1,        1'b0, 33);
        add("DIVU",    32'd100,      32'd7,        3'd5, 7'h01, 32'd14,       1'b0, 33);
        add("REMU",    32'd100,      32'd7,        3'd7, 7'h01, 32'd2,        1'b0, 33);
        add("DIVU0",   32'd9,        32'd0,        3'd5, 7'h01, 32'hFFFFFFFF, 1'b0, 1);
        add("REMU0",   32'd9,        32'd0,        3'd7, 7'h01, 32'd9,        1'b0, 1);
        add("DIV0",    32'd9,        32'd0,        3'd4, 7'h01, 32'hFFFFFFFF, 1'b0, 1);
        add("DIVovf",  32'h80000000, 32'hFFFFFFFF, 3'd4, 7'h01, 32'h80000000, 1'b0, 1);
        add("REMovf",  32'h80000000, 32'hFFFFFFFF, 3'd6, 7'h01, 32'd0,        1'b0, 1);
        add("ILL",     32'd5,        32'd7,        3'd1, 7'h20, 32'd0,        1'b1, 1);
        add("ADDpost", 32'd1,        32'd1,        3'd0, 7'h00, 32'd2,        1'b0, 1);
        add("ILL7F",   32'd5,        32'd7,        3'd0, 7'h7F, 32'd0,        1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            add("ADDrnd", ra, rb, 3'd0, 7'h00, ra + rb, 1'b0, 1);
            add("MULHUrnd", ra, rb, 3'd3, 7'h01, 32'((64'(ra) * 64'(rb)) >> 32), 1'b0, 33);
            rb = rb | 32'd1;
            add("DIVUrnd", ra, rb, 3'd5, 7'h01, ra / rb, 1'b0, 33);
        end

        repeat (3) @(negedge clk);
        check("rst_held out_valid", 32'(out_valid), 32'd0);
        check("rst_held busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out", out, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);
        @(negedge clk);

        for (int i = 0; i < vt.size(); i++) send(vt[i]);
        drain();

        // busy spans exactly the iteration cycles of a multiply
        v.name = "MULHbusy"; v.a = 32'h80000000; v.b = 32'h80000000; v.f3 = 3'd1; v.f7 = 7'h01;
        v.res = 32'h40000000; v.ill = 1'b0; v.lat = 33;
        send(v);
        nb = 0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            if (busy) nb++;
            @(negedge clk);
            guard++;
        end
        check("MULH busy cycles", nb, 32);
        check("MULH busy at done", 32'(busy), 32'd0);
        drain();

        // back-pressure: result held, then consumed on the edge that accepts a new ADD
        out_ready = 1'b0;
        v.name = "MULbp"; v.a = 32'hFFFFFFFD; v.b = 32'd7; v.f3 = 3'd0; v.f7 = 7'h01;
        v.res = 32'hFFFFFFEB; v.ill = 1'b0; v.lat = 33;
        send(v);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp out", out, 32'hFFFFFFEB);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        v.name = "ADDbp"; v.a = 32'd2; v.b = 32'd3; v.f3 = 3'd0; v.f7 = 7'h00;
        v.res = 32'd5; v.lat = 1;
        send(v);
        drain();

        // reset in the middle of a multiply discards it
        v.name = "MULrst"; v.a = 32'h12345678; v.b = 32'h9ABCDEF0; v.f3 = 3'd0; v.f7 = 7'h01;
        v.res = 32'd0; v.lat = 33;
        send(v);
        repeat (10) @(negedge clk);
        check("midop busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out", out, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        v.name = "ADDafter"; v.a = 32'd20; v.b = 32'd22; v.f3 = 3'd0; v.f7 = 7'h00;
        v.res = 32'd42; v.lat = 1;
        send(v);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
